// File: rtl/stg_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | stg_pkg                                                          |
// | Shared game-state encodings, coordinate width, bullet entry.     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package stg_pkg;

   typedef enum logic [3:0] {
      GS_INITIAL   = 4'b0000,
      GS_START     = 4'b0001,
      GS_PLAY      = 4'b0010,
      GS_COLLISION = 4'b1010,
      GS_BOMB      = 4'b0110,
      GS_GAMEOVER  = 4'b1001
   } game_state_e;

   localparam int c_COORD_W = 10;

   typedef struct packed {
      logic                 active;
      logic [c_COORD_W-1:0] x;
      logic [c_COORD_W-1:0] y;
   } bullet_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/collision_detector_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | collision_detector_if                                            |
// | Synchronous-read port into the enemy-bullet table.               |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface collision_detector_if
   import stg_pkg::*;
#(
   parameter int N_BULLETS = 16,
   parameter int COORD_W   = c_COORD_W
) ();
   localparam int c_ADDR_W = $clog2(N_BULLETS);

   logic                bul_rd_en;
   logic [c_ADDR_W-1:0] bul_addr;
   logic                bul_active;
   logic [COORD_W-1:0]  bul_x;
   logic [COORD_W-1:0]  bul_y;

   modport master (
      output bul_rd_en, bul_addr,
      input  bul_active, bul_x, bul_y
   );

   modport slave (
      input  bul_rd_en, bul_addr,
      output bul_active, bul_x, bul_y
   );
endinterface
`default_nettype wire

// File: rtl/hit_compare.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hit_compare                                                      |
// | Square hitbox window test on two unsigned points.                |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module hit_compare
   import stg_pkg::*;
#(
   parameter int COORD_W = c_COORD_W,
   parameter int HIT_R   = 4
) (
   input  wire logic [COORD_W-1:0] i_ax,
   input  wire logic [COORD_W-1:0] i_ay,
   input  wire logic [COORD_W-1:0] i_bx,
   input  wire logic [COORD_W-1:0] i_by,
   output logic                    o_hit
);
   localparam logic [COORD_W:0] c_HIT_R = (COORD_W+1)'(HIT_R);

   logic [COORD_W:0] w_dx;
   logic [COORD_W:0] w_dy;
   logic [COORD_W:0] w_adx;
   logic [COORD_W:0] w_ady;

   // One extra bit keeps the signed difference exact, so far-apart points never alias
   always_comb begin
      w_dx  = {1'b0, i_ax} - {1'b0, i_bx};
      w_dy  = {1'b0, i_ay} - {1'b0, i_by};
      w_adx = w_dx[COORD_W] ? -w_dx : w_dx;
      w_ady = w_dy[COORD_W] ? -w_dy : w_dy;
      o_hit = (w_adx <= c_HIT_R) && (w_ady <= c_HIT_R);
   end
endmodule
`default_nettype wire

// File: rtl/collision_detector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | collision_detector                                               |
// | Per-frame scan of the bullet table against the player hitbox.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module collision_detector
   import stg_pkg::*;
#(
   parameter int N_BULLETS = 16,
   parameter int COORD_W   = c_COORD_W,
   parameter int HIT_R     = 4,
   localparam int c_ADDR_W = $clog2(N_BULLETS)
) (
   input  wire logic                clk,
   input  wire logic                hard_reset,
   input  wire logic                frame_start,
   input  wire logic [3:0]          game_state,
   input  wire logic [COORD_W-1:0]  player_x,
   input  wire logic [COORD_W-1:0]  player_y,
   collision_detector_if.master     bul,
   output logic                     collision,
   output logic [c_ADDR_W-1:0]      hit_index,
   output logic                     busy,
   output logic                     scan_done,
   output logic                     overrun
);
   localparam logic [c_ADDR_W-1:0] c_LAST_ADDR = c_ADDR_W'(N_BULLETS - 1);

   scan_state_e         r_state;
   logic [c_ADDR_W-1:0] r_addr;
   logic                r_rd_en;
   logic                r_cmp_valid;
   logic [c_ADDR_W-1:0] r_cmp_idx;
   logic [COORD_W-1:0]  r_px;
   logic [COORD_W-1:0]  r_py;
   logic                r_collision;
   logic [c_ADDR_W-1:0] r_hit_index;
   logic                r_busy;
   logic                r_scan_done;
   logic                r_overrun;

   logic w_play;
   logic w_window;
   logic w_hit;

   assign w_play = (game_state == GS_PLAY);

   hit_compare #(
      .COORD_W (COORD_W),
      .HIT_R   (HIT_R)
   ) u_hit_compare (
      .i_ax  (bul.bul_x),
      .i_ay  (bul.bul_y),
      .i_bx  (r_px),
      .i_by  (r_py),
      .o_hit (w_window)
   );

   // Compare only the cycle after a read was issued and kept
   assign w_hit = r_cmp_valid && bul.bul_active && w_window;

   always_ff @(posedge clk) begin
      if (hard_reset) begin
         r_state     <= ST_IDLE;
         r_addr      <= '0;
         r_rd_en     <= 1'b0;
         r_cmp_valid <= 1'b0;
         r_cmp_idx   <= '0;
         r_px        <= '0;
         r_py        <= '0;
         r_collision <= 1'b0;
         r_hit_index <= '0;
         r_busy      <= 1'b0;
         r_scan_done <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_collision <= 1'b0;
         r_scan_done <= 1'b0;
         r_cmp_valid <= r_rd_en;
         r_cmp_idx   <= r_addr;
         if (frame_start && r_busy) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (frame_start && w_play) begin
                  r_px    <= player_x;
                  r_py    <= player_y;
                  r_addr  <= '0;
                  r_rd_en <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= ST_SCAN;
               end
            end
            ST_SCAN, ST_DRAIN: begin
               // Leaving PLAY wins over a same-cycle hit
               if (!w_play) begin
                  r_rd_en     <= 1'b0;
                  r_cmp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end else if (w_hit) begin
                  r_collision <= 1'b1;
                  r_scan_done <= 1'b1;
                  r_hit_index <= r_cmp_idx;
                  r_rd_en     <= 1'b0;
                  r_cmp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end else if (r_state == ST_DRAIN) begin
                  r_scan_done <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end else if (r_addr == c_LAST_ADDR) begin
                  r_rd_en <= 1'b0;
                  r_state <= ST_DRAIN;
               end else begin
                  r_addr <= r_addr + c_ADDR_W'(1);
               end
            end
            default: begin
               r_rd_en <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bul.bul_rd_en = r_rd_en;
   assign bul.bul_addr  = r_addr;
   assign collision     = r_collision;
   assign hit_index     = r_hit_index;
   assign busy          = r_busy;
   assign scan_done     = r_scan_done;
   assign overrun       = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_collision_detector.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_collision_detector                                            |
// | Directed vectors and corner sequences for collision_detector.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_collision_detector;
   import stg_pkg::*;

   localparam int c_N   = 16;
   localparam int c_W   = c_COORD_W;
   localparam int c_CYC = 26;

   logic           clk = 1'b0;
   logic           hard_reset;
   logic           frame_start;
   logic [3:0]     game_state;
   logic [c_W-1:0] player_x;
   logic [c_W-1:0] player_y;
   logic           collision;
   logic [3:0]     hit_index;
   logic           busy;
   logic           scan_done;
   logic           overrun;

   collision_detector_if #(.N_BULLETS(c_N), .COORD_W(c_W)) bul_if ();

   collision_detector #(.N_BULLETS(c_N), .COORD_W(c_W), .HIT_R(4)) dut (
      .clk         (clk),
      .hard_reset  (hard_reset),
      .frame_start (frame_start),
      .game_state  (game_state),
      .player_x    (player_x),
      .player_y    (player_y),
      .bul         (bul_if),
      .collision   (collision),
      .hit_index   (hit_index),
      .busy        (busy),
      .scan_done   (scan_done),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   // Bullet table model with one-cycle synchronous read
   bullet_entry_t mem [c_N];
   always @(posedge clk) begin
      if (bul_if.bul_rd_en) begin
         bul_if.bul_active <= mem[bul_if.bul_addr].active;
         bul_if.bul_x      <= mem[bul_if.bul_addr].x;
         bul_if.bul_y      <= mem[bul_if.bul_addr].y;
      end
   end

   typedef struct {
      int px; int py;
      bit fill; int fx; int fy;
      int e0; int e0x; int e0y; bit e0a;
      int e1; int e1x; int e1y; bit e1a;
      bit hit; int idx; int done; int reads;
   } vec_t;

   vec_t vecs [10];

   int checks = 0;
   int errors = 0;
   int coll_n, coll_cyc, coll_idx, done_n, done_cyc, busy_n, reads_n, max_rd;
   logic busy_at [0:c_CYC];
   logic ovr_at  [0:c_CYC];
   int last_idx;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic load(input vec_t v);
      for (int a = 0; a < c_N; a++) begin
         mem[a] = '{v.fill, c_W'(v.fx), c_W'(v.fy)};
      end
      if (v.e0 >= 0) mem[v.e0] = '{v.e0a, c_W'(v.e0x), c_W'(v.e0y)};
      if (v.e1 >= 0) mem[v.e1] = '{v.e1a, c_W'(v.e1x), c_W'(v.e1y)};
      player_x = c_W'(v.px);
      player_y = c_W'(v.py);
   endtask

   // Pulse frame_start in cycle T, then record outputs for cycles T+1..T+c_CYC
   task automatic run_scan(input logic [3:0] gs, input int bomb_at, input int fs2_at, input int rst_at);
      int rd_cnt [c_N];
      for (int a = 0; a < c_N; a++) rd_cnt[a] = 0;
      coll_n = 0; coll_cyc = -1; coll_idx = -1; done_n = 0; done_cyc = -1;
      busy_n = 0; reads_n = 0; max_rd = 0;
      game_state = gs;
      @(negedge clk);
      frame_start = 1'b1;
      for (int c = 1; c <= c_CYC; c++) begin
         @(negedge clk);
         if (collision) begin coll_n++; coll_cyc = c; coll_idx = int'(hit_index); end
         if (scan_done) begin done_n++; done_cyc = c; end
         if (busy) busy_n++;
         busy_at[c] = busy;
         ovr_at[c]  = overrun;
         if (bul_if.bul_rd_en) begin
            reads_n++;
            rd_cnt[bul_if.bul_addr]++;
         end
         frame_start = (c == fs2_at);
         hard_reset  = (c == rst_at);
         if (c == bomb_at) game_state = GS_BOMB;
      end
      for (int a = 0; a < c_N; a++) if (rd_cnt[a] > max_rd) max_rd = rd_cnt[a];
      game_state = GS_PLAY;
   endtask

   initial begin
      hard_reset  = 1'b1;
      frame_start = 1'b0;
      game_state  = GS_PLAY;
      player_x    = '0;
      player_y    = '0;
      last_idx    = 0;
      for (int a = 0; a < c_N; a++) mem[a] = '0;

      //          px  py  fill fx  fy   e0 e0x  e0y e0a  e1 e1x e1y e1a hit idx done reads
      vecs[0] = '{100,100, 0,  0,  0,   5, 103, 97, 1,   -1, 0,  0,  0,  1,  5,  8,  7};
      vecs[1] = '{100,100, 1,200,200,  -1,   0,  0, 0,   -1, 0,  0,  0,  0,  0, 18, 16};
      vecs[2] = '{100,100, 0,  0,  0,   0, 104, 96, 1,   -1, 0,  0,  0,  1,  0,  3,  2};
      vecs[3] = '{100,100, 0,  0,  0,   0, 105,100, 1,   -1, 0,  0,  0,  0,  0, 18, 16};
      vecs[4] = '{  2,  2, 0,  0,  0,   0,1020,  2, 1,   -1, 0,  0,  0,  0,  0, 18, 16};
      vecs[5] = '{100,100, 0,  0,  0,   3, 100,100, 1,    9,101,101, 1,  1,  3,  6,  5};
      vecs[6] = '{100,100, 0,  0,  0,  15,  96,104, 1,   -1, 0,  0,  0,  1, 15, 18, 16};
      vecs[7] = '{100,100, 0,  0,  0,   2, 100,100, 0,   -1, 0,  0,  0,  0,  0, 18, 16};
      vecs[8] = '{100,100, 0,  0,  0,   1, 100, 95, 1,   -1, 0,  0,  0,  0,  0, 18, 16};
      vecs[9] = '{  3,  0, 0,  0,  0,   4,   0,  4, 1,   -1, 0,  0,  0,  1,  4,  7,  6};

      repeat (3) @(negedge clk);
      hard_reset = 1'b0;
      check("rst collision", int'(collision), 0);
      check("rst busy", int'(busy), 0);
      check("rst scan_done", int'(scan_done), 0);
      check("rst overrun", int'(overrun), 0);
      check("rst hit_index", int'(hit_index), 0);
      check("rst rd_en", int'(bul_if.bul_rd_en), 0);
      check("rst addr", int'(bul_if.bul_addr), 0);

      for (int i = 0; i < 10; i++) begin
         load(vecs[i]);
         run_scan(GS_PLAY, -1, -1, -1);
         if (vecs[i].hit) last_idx = vecs[i].idx;
         check($sformatf("v%0d coll_n", i), coll_n, int'(vecs[i].hit));
         if (vecs[i].hit) begin
            check($sformatf("v%0d coll_cyc", i), coll_cyc, vecs[i].done);
            check($sformatf("v%0d coll_idx", i), coll_idx, vecs[i].idx);
         end
         check($sformatf("v%0d done_n", i), done_n, 1);
         check($sformatf("v%0d done_cyc", i), done_cyc, vecs[i].done);
         check($sformatf("v%0d busy_n", i), busy_n, vecs[i].done - 1);
         check($sformatf("v%0d reads", i), reads_n, vecs[i].reads);
         check($sformatf("v%0d max_rd", i), max_rd, 1);
         check($sformatf("v%0d hit_index held", i), int'(hit_index), last_idx);
      end

      // Leaving PLAY mid-scan with a hitting entry 6
      load('{100,100, 0,0,0, 6,100,100,1, -1,0,0,0, 1,6,9,8});
      run_scan(GS_PLAY, 4, -1, -1);
      check("bomb busy T+4", int'(busy_at[4]), 1);
      check("bomb busy T+5", int'(busy_at[5]), 0);
      check("bomb coll_n", coll_n, 0);
      check("bomb done_n", done_n, 0);
      check("bomb reads", reads_n, 4);
      check("bomb hit_index held", int'(hit_index), last_idx);

      run_scan(GS_GAMEOVER, -1, -1, -1);
      check("gameover reads", reads_n, 0);
      check("gameover busy_n", busy_n, 0);
      check("gameover done_n", done_n, 0);

      // Second frame_start during a scan
      load(vecs[0]);
      run_scan(GS_PLAY, -1, 5, -1);
      check("ovr T+5", int'(ovr_at[5]), 0);
      check("ovr T+6", int'(ovr_at[6]), 1);
      check("ovr held", int'(ovr_at[c_CYC]), 1);
      check("ovr coll_cyc", coll_cyc, 8);
      check("ovr coll_idx", coll_idx, 5);
      check("ovr done_n", done_n, 1);
      check("ovr done_cyc", done_cyc, 8);

      // hard_reset mid-scan clears everything before the hit lands
      run_scan(GS_PLAY, -1, 5, 6);
      check("rst2 ovr T+6", int'(ovr_at[6]), 1);
      check("rst2 ovr T+7", int'(ovr_at[7]), 0);
      check("rst2 busy T+7", int'(busy_at[7]), 0);
      check("rst2 coll_n", coll_n, 0);
      check("rst2 done_n", done_n, 0);
      check("rst2 hit_index", int'(hit_index), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
